game_state_ctrl: RTL and testbench
==================================

# game_state_ctrl

Central game sequencer for the Bomb Squad design: it produces the 8-bit game-state code consumed by the LED animation and display blocks. It owns the following:
- the authentication attempt counter
- the game countdown timer
- the strike counter
- the timed success and game-over sequences

It sits between the input-handling blocks (authentication checker, wire/module logic, player buttons) and every state-driven output block.

## Interface
Parameters:
- TICK_DIV, 50_000_000: clk cycles per game tick (1 s at 50 MHz)
- HOLD_TICKS, 2: ticks spent in AUTH_OK / AUTH_FAIL
- SEQ_TICKS, 3: ticks spent in WIN_BEGIN / LOSE_BEGIN
- GAME_SECONDS, 99: countdown start value (max 127)
- MAX_STRIKES, 3: strikes that end the game (1..3)
- AUTH_RETRIES, 3: failed attempts before lockout (1..7)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clears all state
- auth_pass  in  1  one-cycle pulse, credentials accepted
- auth_fail  in  1  one-cycle pulse, credentials rejected
- module_solved  in  1  one-cycle pulse, bomb defused
- strike  in  1  one-cycle pulse, wrong action
- ack  in  1  player acknowledge (level, sampled each cycle)
- state  out  8  game-state code
- time_left  out  7  remaining seconds
- strikes  out  2  strike count
- locked  out  1  authentication lockout

## Operation
State codes:
- 0x00 AUTH
- 0x01 AUTH_OK
- 0x02 AUTH_FAIL
- 0x10 PLAY
- 0x20 WIN_BEGIN
- 0x21 WIN_END
- 0x30 LOSE_BEGIN
- 0x31 LOSE_END

The `state` output is the registered state code. No other values are ever driven.

Transitions:
- AUTH:
  - auth_fail → AUTH_FAIL, fail_cnt+1.
  - Otherwise auth_pass → AUTH_OK.
  - Both in the same cycle: fail wins.
- AUTH_OK: after HOLD_TICKS ticks → PLAY. On entry to PLAY, load time_left=GAME_SECONDS and strikes=0.
- AUTH_FAIL: after HOLD_TICKS ticks:
  - If fail_cnt<AUTH_RETRIES → AUTH.
  - Else remain in AUTH_FAIL with locked=1 permanently. Only reset clears it; all inputs are ignored.
- PLAY, evaluated every cycle in priority order:
  1. Loss: strike that makes strikes==MAX_STRIKES, or a tick with time_left==1 (time_left→0). → LOSE_BEGIN.
  2. module_solved → WIN_BEGIN.
  3. A strike below the limit increments strikes.
  4. A tick decrements time_left.
- WIN_BEGIN / LOSE_BEGIN: after SEQ_TICKS ticks → WIN_END / LOSE_END.
- WIN_END / LOSE_END:
  - ack=1 → AUTH, with fail_cnt=0.
  - time_left and strikes hold their final values until the next PLAY entry.

Input handling:
- auth_pass/auth_fail are ignored outside AUTH.
- module_solved/strike are ignored outside PLAY.
- ack is ignored outside WIN_END/LOSE_END.

Width and range rules:
- time_left never wraps below 0.
- strikes saturates at MAX_STRIKES.
- fail_cnt is 3 bits and saturates at AUTH_RETRIES.

## Timing
- Reset values:
  - state=0x00
  - time_left=0
  - strikes=0
  - locked=0
  - fail_cnt=0
  - prescaler=0
- Latency: an input pulse sampled at edge N is reflected in state/time_left/strikes after edge N (visible in cycle N+1). No combinational input→output paths.
- Tick generation: the prescaler counts 0..TICK_DIV-1. The tick pulse occurs when the count equals TICK_DIV-1. The prescaler restarts at 0 on every state change.
- Exact durations:
  - First PLAY decrement occurs TICK_DIV cycles after PLAY entry.
  - AUTH_OK/AUTH_FAIL last exactly HOLD_TICKS·TICK_DIV cycles.
  - WIN_BEGIN/LOSE_BEGIN last exactly SEQ_TICKS·TICK_DIV cycles.
- Hold/sequence tick count: resets to 0 on state entry. The transition fires on the cycle of the final tick.
- locked asserts in the same cycle the hold completes with fail_cnt==AUTH_RETRIES.
- Reset asserted mid-operation, in any state: returns to reset values on the next edge. Any in-progress hold or sequence is discarded.

## Structure
- Shared package `bomb_squad_pkg`:
  - the eight state-code constants
  - the 8-bit state type

  The LED driver and displays import the same constants.
- Sub-module `tick_gen`: parameterised prescaler with a synchronous `restart` input and a one-cycle `tick` output. Instantiated once.
- The FSM, counters and priority logic live in `game_state_ctrl`.

## Test plan
Bench parameters: TICK_DIV=4, HOLD_TICKS=2, SEQ_TICKS=3, GAME_SECONDS=5, MAX_STRIKES=3, AUTH_RETRIES=3.

- **Reset:** hold reset 3 cycles → state=0x00, time_left=0, strikes=0, locked=0. Pulse auth_pass during reset → still 0x00.
- **Auth pass and timeout loss:** auth_pass → state=0x01 for exactly 8 cycles, then 0x10 with time_left=5.
  - time_left decrements every 4 cycles: 4,3,2,1.
  - On the 5th tick → 0x30. After 12 cycles → 0x31.
  - ack → 0x00.
- **Lockout:** three auth_fail pulses, each followed by the 8-cycle 0x02 hold. The first two return to 0x00. The third stays at 0x02 with locked=1, and a later auth_pass has no effect.
- **Strikes:** in PLAY, pulse strike 3 times → strikes=1,2, then state=0x30 on the third. Strike and module_solved in the same cycle at strikes=2 → 0x30.
- **Win:** in PLAY at time_left=3, pulse module_solved → 0x20 for 12 cycles, then 0x21 with time_left frozen at 3. ack → 0x00, then a new auth_pass is accepted.
- **Reset mid-sequence:** assert reset while in 0x20 → state=0x00, time_left=0 on the next edge.

Source files
------------

// File: rtl/bomb_squad_pkg.sv
// Bomb Squad shared definitions: game-state codes
// used by the sequencer, LED animation and displays.
package bomb_squad_pkg;

   typedef enum logic [7:0] {
      AUTH       = 8'h00,
      AUTH_OK    = 8'h01,
      AUTH_FAIL  = 8'h02,
      PLAY       = 8'h10,
      WIN_BEGIN  = 8'h20,
      WIN_END    = 8'h21,
      LOSE_BEGIN = 8'h30,
      LOSE_END   = 8'h31
   } state_t;

endpackage

// File: rtl/tick_gen.sv
// Game-tick prescaler: one-cycle tick every DIV clocks,
// realigned to zero by a synchronous restart.
module tick_gen #(
   parameter int DIV = 50_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST);

   // count 0..DIV-1, wrapping on tick, zeroed on restart
   always_ff @(posedge clk) begin
      if (reset || restart)
         cnt <= '0;
      else if (tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/game_state_ctrl.sv
// Bomb Squad sequencer: auth attempts, countdown,
// strikes and the timed win/lose sequences.
module game_state_ctrl
   import bomb_squad_pkg::*;
#(
   parameter int TICK_DIV     = 50_000_000,
   parameter int HOLD_TICKS   = 2,
   parameter int SEQ_TICKS    = 3,
   parameter int GAME_SECONDS = 99,
   parameter int MAX_STRIKES  = 3,
   parameter int AUTH_RETRIES = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       auth_pass,
   input  logic       auth_fail,
   input  logic       module_solved,
   input  logic       strike,
   input  logic       ack,
   output state_t     state,
   output logic [6:0] time_left,
   output logic [1:0] strikes,
   output logic       locked
);

   localparam int HMAX =
      (HOLD_TICKS > SEQ_TICKS) ? HOLD_TICKS : SEQ_TICKS;
   localparam int HW = $clog2(HMAX + 1);

   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
   localparam logic [HW-1:0] SEQ_LAST  = HW'(SEQ_TICKS - 1);
   localparam logic [6:0] TIME_INIT   = 7'(GAME_SECONDS);
   localparam logic [1:0] STRIKE_MAX  = 2'(MAX_STRIKES);
   localparam logic [1:0] STRIKE_LAST = 2'(MAX_STRIKES - 1);
   localparam logic [2:0] RETRY_MAX   = 3'(AUTH_RETRIES);

   state_t          state_nx;
   logic [6:0]      time_nx;
   logic [1:0]      strikes_nx;
   logic [2:0]      fail_cnt;
   logic [2:0]      fail_nx;
   logic            locked_nx;
   logic [HW-1:0]   hcnt;
   logic            tick;
   logic            restart;
   logic            hold_done;
   logic            seq_done;
   logic            loss_strike;
   logic            loss_time;

   // prescaler realigns on every state change
   assign restart = (state_nx != state);

   tick_gen #(
      .DIV(TICK_DIV)
   ) u_tick (
      .clk(clk),
      .reset(reset),
      .restart(restart),
      .tick(tick)
   );

   assign hold_done   = tick && (hcnt == HOLD_LAST);
   assign seq_done    = tick && (hcnt == SEQ_LAST);
   assign loss_strike = strike && (strikes == STRIKE_LAST);
   assign loss_time   = tick && (time_left == 7'd1);

   // ticks elapsed in the current hold/sequence state
   always_ff @(posedge clk) begin
      if (reset || restart)
         hcnt <= '0;
      else if (tick)
         hcnt <= hcnt + 1'b1;
   end

   // state and counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= AUTH;
         time_left <= '0;
         strikes   <= '0;
         fail_cnt  <= '0;
         locked    <= 1'b0;
      end else begin
         state     <= state_nx;
         time_left <= time_nx;
         strikes   <= strikes_nx;
         fail_cnt  <= fail_nx;
         locked    <= locked_nx;
      end
   end

   // next-state and counter update in priority order
   always_comb begin
      state_nx   = state;
      time_nx    = time_left;
      strikes_nx = strikes;
      fail_nx    = fail_cnt;
      locked_nx  = locked;
      unique case (state)
         AUTH: begin
            if (auth_fail) begin
               state_nx = AUTH_FAIL;
               if (fail_cnt < RETRY_MAX)
                  fail_nx = fail_cnt + 3'd1;
            end else if (auth_pass) begin
               state_nx = AUTH_OK;
            end
         end
         AUTH_OK: begin
            if (hold_done) begin
               state_nx   = PLAY;
               time_nx    = TIME_INIT;
               strikes_nx = '0;
            end
         end
         AUTH_FAIL: begin
            if (!locked && hold_done) begin
               if (fail_cnt < RETRY_MAX)
                  state_nx = AUTH;
               else
                  locked_nx = 1'b1;
            end
         end
         PLAY: begin
            if (loss_strike || loss_time) begin
               state_nx = LOSE_BEGIN;
               if (loss_strike)
                  strikes_nx = STRIKE_MAX;
               if (loss_time)
                  time_nx = '0;
            end else if (module_solved) begin
               state_nx = WIN_BEGIN;
            end else begin
               if (strike && strikes < STRIKE_MAX)
                  strikes_nx = strikes + 2'd1;
               if (tick && time_left != 7'd0)
                  time_nx = time_left - 7'd1;
            end
         end
         WIN_BEGIN: begin
            if (seq_done)
               state_nx = WIN_END;
         end
         LOSE_BEGIN: begin
            if (seq_done)
               state_nx = LOSE_END;
         end
         WIN_END, LOSE_END: begin
            if (ack) begin
               state_nx = AUTH;
               fail_nx  = '0;
            end
         end
         default: begin
            state_nx = AUTH;
         end
      endcase
   end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl with a short
// tick so every timed path is exercised.
module tb_game_state_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       auth_pass = 1'b0;
   logic       auth_fail = 1'b0;
   logic       module_solved = 1'b0;
   logic       strike = 1'b0;
   logic       ack = 1'b0;
   logic [7:0] state;
   logic [6:0] time_left;
   logic [1:0] strikes;
   logic       locked;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   game_state_ctrl #(
      .TICK_DIV(4),
      .HOLD_TICKS(2),
      .SEQ_TICKS(3),
      .GAME_SECONDS(5),
      .MAX_STRIKES(3),
      .AUTH_RETRIES(3)
   ) dut (
      .clk(clk),
      .reset(reset),
      .auth_pass(auth_pass),
      .auth_fail(auth_fail),
      .module_solved(module_solved),
      .strike(strike),
      .ack(ack),
      .state(state),
      .time_left(time_left),
      .strikes(strikes),
      .locked(locked)
   );

   task automatic chk(input string tag, input int got,
                      input int exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic go_play();
      auth_pass = 1'b1;
      cyc(1);
      auth_pass = 1'b0;
      chk("enter_ok", int'(state), 'h01);
      cyc(8);
      chk("enter_play", int'(state), 'h10);
      chk("play_time", int'(time_left), 5);
      chk("play_strikes", int'(strikes), 0);
   endtask

   initial begin
      // reset, with auth_pass held high
      auth_pass = 1'b1;
      cyc(3);
      chk("rst_state", int'(state), 'h00);
      chk("rst_time", int'(time_left), 0);
      chk("rst_strikes", int'(strikes), 0);
      chk("rst_locked", int'(locked), 0);
      reset = 1'b0;
      auth_pass = 1'b0;

      // auth pass, then loss by timeout
      auth_pass = 1'b1;
      cyc(1);
      auth_pass = 1'b0;
      chk("ok_first", int'(state), 'h01);
      cyc(7);
      chk("ok_last", int'(state), 'h01);
      cyc(1);
      chk("play", int'(state), 'h10);
      chk("time5", int'(time_left), 5);
      cyc(3);
      chk("time5_hold", int'(time_left), 5);
      cyc(1);
      chk("time4", int'(time_left), 4);
      cyc(4);
      chk("time3", int'(time_left), 3);
      cyc(4);
      chk("time2", int'(time_left), 2);
      cyc(4);
      chk("time1", int'(time_left), 1);
      cyc(3);
      chk("before_lose", int'(state), 'h10);
      cyc(1);
      chk("lose_begin", int'(state), 'h30);
      chk("time0", int'(time_left), 0);
      cyc(11);
      chk("lose_seq_last", int'(state), 'h30);
      cyc(1);
      chk("lose_end", int'(state), 'h31);
      chk("lose_time_hold", int'(time_left), 0);
      ack = 1'b1;
      cyc(1);
      ack = 1'b0;
      chk("ack_auth", int'(state), 'h00);

      // lockout after three failures
      for (int i = 0; i < 3; i++) begin
         auth_fail = 1'b1;
         cyc(1);
         auth_fail = 1'b0;
         chk("fail_enter", int'(state), 'h02);
         cyc(7);
         chk("fail_hold", int'(state), 'h02);
         cyc(1);
         chk("fail_exit", int'(state), (i < 2) ? 'h00 : 'h02);
         chk("fail_locked", int'(locked), (i < 2) ? 0 : 1);
      end
      auth_pass = 1'b1;
      cyc(1);
      auth_pass = 1'b0;
      chk("locked_pass", int'(state), 'h02);
      cyc(10);
      chk("locked_stay", int'(state), 'h02);
      chk("locked_stay_l", int'(locked), 1);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      chk("unlock_state", int'(state), 'h00);
      chk("unlock_locked", int'(locked), 0);

      // strikes up to the limit
      go_play();
      strike = 1'b1;
      cyc(1);
      chk("strike1", int'(strikes), 1);
      cyc(1);
      chk("strike2", int'(strikes), 2);
      chk("strike2_state", int'(state), 'h10);
      cyc(1);
      strike = 1'b0;
      chk("strike3_lose", int'(state), 'h30);
      chk("strike3_sat", int'(strikes), 3);
      strike = 1'b1;
      cyc(1);
      strike = 1'b0;
      chk("strike_ignored", int'(strikes), 3);
      cyc(11);
      chk("strike_lose_end", int'(state), 'h31);
      ack = 1'b1;
      cyc(1);
      ack = 1'b0;
      chk("strike_ack", int'(state), 'h00);

      // strike beats module_solved at the limit
      go_play();
      strike = 1'b1;
      cyc(2);
      chk("pri_strike2", int'(strikes), 2);
      module_solved = 1'b1;
      cyc(1);
      strike = 1'b0;
      module_solved = 1'b0;
      chk("pri_lose", int'(state), 'h30);
      cyc(12);
      chk("pri_lose_end", int'(state), 'h31);
      ack = 1'b1;
      cyc(1);
      ack = 1'b0;
      chk("pri_ack", int'(state), 'h00);

      // win with time frozen at 3
      go_play();
      cyc(8);
      chk("win_time3", int'(time_left), 3);
      module_solved = 1'b1;
      cyc(1);
      module_solved = 1'b0;
      chk("win_begin", int'(state), 'h20);
      cyc(11);
      chk("win_seq_last", int'(state), 'h20);
      cyc(1);
      chk("win_end", int'(state), 'h21);
      chk("win_time_hold", int'(time_left), 3);
      ack = 1'b1;
      cyc(1);
      ack = 1'b0;
      chk("win_ack", int'(state), 'h00);
      auth_pass = 1'b1;
      cyc(1);
      auth_pass = 1'b0;
      chk("reauth", int'(state), 'h01);

      // reset in the middle of the win sequence
      cyc(8);
      chk("rs_play", int'(state), 'h10);
      module_solved = 1'b1;
      cyc(1);
      module_solved = 1'b0;
      chk("rs_win", int'(state), 'h20);
      cyc(2);
      reset = 1'b1;
      cyc(1);
      chk("rs_state", int'(state), 'h00);
      chk("rs_time", int'(time_left), 0);
      reset = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
